// File: rtl/tft_spi_if.sv
// Byte handshake between the TFT command/pixel sequencer (master) and the
// SPI byte transmitter (slave).
interface tft_spi_if;
  logic       send_en;
  logic       send_dc;
  logic [7:0] send_data;
  logic       send_busy;
  logic       send_done;

  modport master (output send_en, output send_dc, output send_data,
                  input  send_busy, input send_done);
  modport slave  (input  send_en, input send_dc, input send_data,
                  output send_busy, output send_done);
endinterface

// File: rtl/tft_spi_tx.sv
// Byte-level SPI mode-0 master (MSB first) for the ILI9341 4-wire serial port.
// One CS_n frame per byte, followed by a CS-high gap before the next accept.
module tft_spi_tx #(
  parameter int CLK_DIV     = 4,
  parameter int CS_IDLE_CYC = 2
) (
  input  logic    clk,
  input  logic    rst_n,
  tft_spi_if.slave bus,
  output logic    spi_sclk,
  output logic    spi_mosi,
  output logic    spi_cs_n,
  output logic    spi_dc
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_HIGH  = 3'd2;
  localparam logic [2:0] S_LOW   = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  localparam logic [7:0] DIV_RELOAD = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_RELOAD = 8'(CS_IDLE_CYC - 1);

  logic [2:0] state_q, state_d;
  logic [7:0] div_q,   div_d;
  logic [2:0] bit_q,   bit_d;
  // Bit 7 goes straight to MOSI at accept, so only bits 6..0 are held here.
  logic [6:0] shift_q, shift_d;
  logic       sclk_q,  sclk_d;
  logic       mosi_q,  mosi_d;
  logic       cs_n_q,  cs_n_d;
  logic       dc_q,    dc_d;
  logic       busy_q,  busy_d;
  logic       done_q,  done_d;

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    cs_n_d  = cs_n_q;
    dc_d    = dc_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.send_en) begin
          state_d = S_SETUP;
          shift_d = bus.send_data[6:0];
          mosi_d  = bus.send_data[7];
          dc_d    = bus.send_dc;
          cs_n_d  = 1'b0;
          busy_d  = 1'b1;
          div_d   = DIV_RELOAD;
          bit_d   = 3'd7;
        end
      end
      S_SETUP: begin
        if (div_q == 8'd0) begin
          state_d = S_HIGH;
          sclk_d  = 1'b1;
          div_d   = DIV_RELOAD;
        end else begin
          div_d = div_q - 8'd1;
        end
      end
      S_HIGH: begin
        if (div_q == 8'd0) begin
          state_d = S_LOW;
          sclk_d  = 1'b0;
          div_d   = DIV_RELOAD;
          // After the last rising edge MOSI keeps bit0 for the CS hold time.
          if (bit_q != 3'd0) begin
            mosi_d  = shift_q[6];
            shift_d = {shift_q[5:0], 1'b0};
          end
        end else begin
          div_d = div_q - 8'd1;
        end
      end
      S_LOW: begin
        if (div_q == 8'd0) begin
          if (bit_q == 3'd0) begin
            state_d = S_GAP;
            cs_n_d  = 1'b1;
            div_d   = GAP_RELOAD;
          end else begin
            state_d = S_HIGH;
            sclk_d  = 1'b1;
            bit_d   = bit_q - 3'd1;
            div_d   = DIV_RELOAD;
          end
        end else begin
          div_d = div_q - 8'd1;
        end
      end
      S_GAP: begin
        if (div_q == 8'd0) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          div_d   = 8'd0;
        end else begin
          div_d = div_q - 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        div_d   = 8'd0;
        bit_d   = 3'd0;
        sclk_d  = 1'b0;
        cs_n_d  = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all of them update
  // together from the values computed above, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      div_q   <= 8'd0;
      bit_q   <= 3'd0;
      shift_q <= 7'd0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      dc_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      cs_n_q  <= cs_n_d;
      dc_q    <= dc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.send_busy = busy_q;
  assign bus.send_done = done_q;
  assign spi_sclk      = sclk_q;
  assign spi_mosi      = mosi_q;
  assign spi_cs_n      = cs_n_q;
  assign spi_dc        = dc_q;

endmodule
